// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, writeback ports A/B, reservation and debug read.
// The master side drives requests; the slave side (the register file) answers.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_ready;
    logic            rs2_ready;

    logic            wa_en;
    logic [AW-1:0]   wa_addr;
    logic [XLEN-1:0] wa_data;

    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            rsv_ok;

    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    logic [AW:0]     busy_cnt;
    logic            err_waw;

    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport master (
        output rs1_addr, rs2_addr, wa_en, wa_addr, wa_data,
               rsv_en, rsv_addr, wb_en, wb_addr, wb_data, dbg_addr,
        input  rs1_data, rs2_data, rs1_ready, rs2_ready, rsv_ok,
               busy_cnt, err_waw, dbg_data
    );

    modport slave (
        input  rs1_addr, rs2_addr, wa_en, wa_addr, wa_data,
               rsv_en, rsv_addr, wb_en, wb_addr, wb_data, dbg_addr,
        output rs1_data, rs2_data, rs1_ready, rs2_ready, rsv_ok,
               busy_cnt, err_waw, dbg_data
    );
endinterface

// File: rtl/regfile_sb.sv
// Scoreboarded register file: two read ports, a short-latency writeback port A,
// a long-latency completion port B, and per-register busy bits set by
// reservations. Register 0 is hardwired to zero and never busy.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] mem_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic [AW:0]      busy_cnt_r;
    logic [AW:0]      busy_cnt_nxt_s;
    logic             err_waw_r;
    logic             err_set_s;
    logic             wa_acc_s;
    logic             wb_act_s;
    logic             rsv_ok_s;

    // Forwarding mux: completion data beats accepted port-A data beats the array.
    function automatic logic [XLEN-1:0] read_mux(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] arr_val,
        input logic            b_act,
        input logic [AW-1:0]   b_addr,
        input logic [XLEN-1:0] b_data,
        input logic            a_act,
        input logic [AW-1:0]   a_addr,
        input logic [XLEN-1:0] a_data
    );
        logic [XLEN-1:0] val;
        if (addr == {AW{1'b0}}) begin
            val = {XLEN{1'b0}};
        end else if ((BYPASS != 0) && b_act && (b_addr == addr)) begin
            val = b_data;
        end else if ((BYPASS != 0) && a_act && (a_addr == addr)) begin
            val = a_data;
        end else begin
            val = arr_val;
        end
        return val;
    endfunction

    // An operand is ready when not pending, or when its completion arrives this cycle.
    function automatic logic ready_of(
        input logic [AW-1:0] addr,
        input logic          busy_bit,
        input logic          b_en,
        input logic [AW-1:0] b_addr
    );
        return (addr == {AW{1'b0}}) || !busy_bit || (b_en && (b_addr == addr));
    endfunction

    // Qualify port A, port B and reservation requests against the current busy state.
    always_comb begin
        wa_acc_s  = bus.wa_en && (bus.wa_addr != {AW{1'b0}}) && !busy_r[bus.wa_addr];
        wb_act_s  = bus.wb_en && (bus.wb_addr != {AW{1'b0}});
        rsv_ok_s  = !rst && bus.rsv_en && (bus.rsv_addr != {AW{1'b0}}) &&
                    (!busy_r[bus.rsv_addr] || (bus.wb_en && (bus.wb_addr == bus.rsv_addr)));
        err_set_s = (bus.wa_en && (bus.wa_addr != {AW{1'b0}}) && busy_r[bus.wa_addr]) ||
                    (wb_act_s && !busy_r[bus.wb_addr]);
    end

    // Next busy vector (completion clears, reservation sets and wins) and its popcount.
    always_comb begin
        busy_nxt_s     = {NREGS{1'b0}};
        busy_cnt_nxt_s = {(AW + 1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            busy_nxt_s[i] = (busy_r[i] && !(wb_act_s && (bus.wb_addr == AW'(i)))) ||
                            (rsv_ok_s && (bus.rsv_addr == AW'(i)));
            busy_cnt_nxt_s = busy_cnt_nxt_s + {{AW{1'b0}}, busy_nxt_s[i]};
        end
    end

    // State update; port B is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
            busy_r     <= {NREGS{1'b0}};
            busy_cnt_r <= {(AW + 1){1'b0}};
            err_waw_r  <= 1'b0;
        end else begin
            if (wa_acc_s) begin
                mem_r[bus.wa_addr] <= bus.wa_data;
            end
            if (wb_act_s) begin
                mem_r[bus.wb_addr] <= bus.wb_data;
            end
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= busy_cnt_nxt_s;
            err_waw_r  <= err_waw_r | err_set_s;
        end
    end

    // Read ports, readiness, debug view of the raw array and registered status.
    always_comb begin
        bus.rs1_data  = read_mux(bus.rs1_addr, mem_r[bus.rs1_addr], wb_act_s, bus.wb_addr,
                                 bus.wb_data, wa_acc_s, bus.wa_addr, bus.wa_data);
        bus.rs2_data  = read_mux(bus.rs2_addr, mem_r[bus.rs2_addr], wb_act_s, bus.wb_addr,
                                 bus.wb_data, wa_acc_s, bus.wa_addr, bus.wa_data);
        bus.rs1_ready = ready_of(bus.rs1_addr, busy_r[bus.rs1_addr], bus.wb_en, bus.wb_addr);
        bus.rs2_ready = ready_of(bus.rs2_addr, busy_r[bus.rs2_addr], bus.wb_en, bus.wb_addr);
        bus.rsv_ok    = rsv_ok_s;
        bus.busy_cnt  = busy_cnt_r;
        bus.err_waw   = err_waw_r;
        if (bus.dbg_addr == {AW{1'b0}}) begin
            bus.dbg_data = {XLEN{1'b0}};
        end else begin
            bus.dbg_data = mem_r[bus.dbg_addr];
        end
    end
endmodule
